// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MIPS32 memory access controller.
// Holds the controller state enum, the access size codes, the default RAM
// geometry and the latched request payload.
package mem_ctrl_pkg;

    localparam int unsigned MEM_ADDR_W = 9;
    localparam int unsigned MEM_WORDS  = 2**MEM_ADDR_W;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef logic [1:0] size_t;

    localparam size_t SZ_BYTE = 2'd0;
    localparam size_t SZ_HALF = 2'd1;
    localparam size_t SZ_WORD = 2'd2;

    // Request fields captured when a request is accepted in IDLE.
    typedef struct packed {
        logic              wr;
        size_t             size;
        logic              uns;
        logic [31:0]       addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU request/response handshake plus the RAM port of the memory controller.
// Modports:
//   slave  - the controller: takes CPU requests, drives the RAM port.
//   master - the CPU + RAM side: issues requests, returns RAM read data.
// Signals: req, wr, size, uns, byte_addr, wdata, ready, done, err, rdata,
//          ram_nce, ram_re, ram_we, ram_addr, ram_din, ram_dout.
interface mem_ctrl_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic              uns;
    logic [31:0]       byte_addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic              ram_nce;
    logic              ram_re;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;

    modport slave (
        input  req, wr, size, uns, byte_addr, wdata, ram_dout,
        output ready, done, err, rdata, ram_nce, ram_re, ram_we, ram_addr, ram_din
    );

    modport master (
        output req, wr, size, uns, byte_addr, wdata, ram_dout,
        input  ready, done, err, rdata, ram_nce, ram_re, ram_we, ram_addr, ram_din
    );

endinterface

// File: rtl/mem_lane_merge.sv
// Combinational little-endian lane handling for sub-word accesses.
// Ports:
//   i_buf     - word read from RAM that a partial store modifies
//   i_wdata   - right-justified store data
//   i_word    - word a load extracts from
//   i_size    - access size code
//   i_addr_lo - byte address bits [1:0]
//   i_uns     - zero-extend loads when 1
//   o_merged  - word to write back (i_wdata unchanged for word stores)
//   o_rdata   - extended load result
module mem_lane_merge
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] i_buf,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_word,
    input  size_t       i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_uns,
    output logic [31:0] o_merged,
    output logic [31:0] o_rdata
);

    logic [4:0]  w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Halfword lanes use addr[1] only, so an unaligned halfword folds onto its lane.
    assign w_shift = {i_addr_lo, 3'b000};
    assign w_byte  = 8'(i_word >> w_shift);
    assign w_half  = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    // Store merge: replace the addressed lane of the buffered word.
    always_comb begin
        o_merged = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_merged               = i_buf;
                o_merged[w_shift +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_merged = i_buf;
                if (i_addr_lo[1]) begin
                    o_merged[31:16] = i_wdata[15:0];
                end else begin
                    o_merged[15:0] = i_wdata[15:0];
                end
            end
            default: ;
        endcase
    end

    // Load extract: sign- or zero-extend the addressed lane.
    always_comb begin
        o_rdata = i_word;
        case (i_size)
            SZ_BYTE: o_rdata = {{24{~i_uns & w_byte[7]}}, w_byte};
            SZ_HALF: o_rdata = {{16{~i_uns & w_half[15]}}, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory access controller: turns byte-addressed CPU loads/stores into
// cycles on a 2**ADDR_W x 32 word RAM, one request at a time. Partial
// stores are done as read-modify-write.
// Ports:
//   clk  - system clock, rising edge
//   nrst - asynchronous active-low reset
//   bus  - mem_ctrl_if.slave: CPU handshake (req/wr/size/uns/byte_addr/
//          wdata -> ready/done/err/rdata) and RAM port (ram_nce/ram_re/
//          ram_we/ram_addr/ram_din, ram_dout)
// Build option: MEM_CTRL_ALIGN_CHECK_EN makes misaligned halfword/word
// accesses complete with err=1 and no RAM cycle; otherwise low address bits
// are masked and err stays 0.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W
) (
    input  logic        clk,
    input  logic        nrst,
    mem_ctrl_if.slave   bus
);

    state_e      r_state, w_state_nx;
    req_t        r_req, w_req_nx;
    logic [31:0] r_buf, w_buf_nx;
    logic [31:0] r_rdata, w_rdata_nx;
    logic        r_ready, w_ready_nx;
    logic        r_done, w_done_nx;
    logic        r_err, w_err_nx;
    logic        w_misalign;
    logic [31:0] w_merged;
    logic [31:0] w_extract;
    logic        w_unused_addr;

    // Byte address bits above the RAM word range are ignored (addresses wrap).
    assign w_unused_addr = ^r_req.addr[31:ADDR_W+2];

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    assign w_misalign = ((bus.size == SZ_HALF) && bus.byte_addr[0])
                     || (bus.size[1] && (bus.byte_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Lane merge for stores (from the buffered word), extract for loads (live RAM data).
    mem_lane_merge u_lane (
        .i_buf     (r_buf),
        .i_wdata   (r_req.wdata),
        .i_word    (bus.ram_dout),
        .i_size    (r_req.size),
        .i_addr_lo (r_req.addr[1:0]),
        .i_uns     (r_req.uns),
        .o_merged  (w_merged),
        .o_rdata   (w_extract)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_req   <= '0;
            r_buf   <= '0;
            r_rdata <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_req   <= w_req_nx;
            r_buf   <= w_buf_nx;
            r_rdata <= w_rdata_nx;
            r_ready <= w_ready_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
        end
    end

    // Next state and next register values.
    always_comb begin
        w_state_nx = r_state;
        w_req_nx   = r_req;
        w_buf_nx   = r_buf;
        w_rdata_nx = r_rdata;
        w_err_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req) begin
                    w_req_nx = '{wr: bus.wr, size: bus.size, uns: bus.uns,
                                 addr: bus.byte_addr, wdata: bus.wdata};
                    if (w_misalign) begin
                        w_state_nx = DONE;
                        w_err_nx   = 1'b1;
                    end else if (!bus.wr || !bus.size[1]) begin
                        w_state_nx = RD;
                    end else begin
                        w_state_nx = WR;
                    end
                end
            end
            RD: begin
                w_buf_nx = bus.ram_dout;
                if (r_req.wr) begin
                    w_state_nx = WR;
                end else begin
                    w_state_nx = DONE;
                    w_rdata_nx = w_extract;
                end
            end
            WR:      w_state_nx = DONE;
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
        w_ready_nx = (w_state_nx == IDLE);
        w_done_nx  = (w_state_nx == DONE);
    end

    // RAM strobes decode from the state register only, so they cannot glitch.
    always_comb begin
        bus.ram_nce = 1'b1;
        bus.ram_re  = 1'b0;
        bus.ram_we  = 1'b0;
        bus.ram_din = '0;
        case (r_state)
            RD: begin
                bus.ram_nce = 1'b0;
                bus.ram_re  = 1'b1;
            end
            WR: begin
                bus.ram_nce = 1'b0;
                bus.ram_we  = 1'b1;
                bus.ram_din = w_merged;
            end
            default: ;
        endcase
    end

    assign bus.ram_addr = r_req.addr[ADDR_W+1:2];
    assign bus.ready    = r_ready;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.rdata    = r_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios followed by random
// loads/stores, checked against a byte-lane memory model.
module tb_mem_ctrl;

    localparam int unsigned AW    = 9;
    localparam int unsigned WORDS = 2**AW;

    logic clk;
    logic nrst;
    int   checks;
    int   failures;

    mem_ctrl_if #(.ADDR_W(AW)) bus ();

    mem_ctrl #(.ADDR_W(AW)) u_dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: combinational read, write on the falling edge.
    logic [31:0] ram [WORDS];
    logic        ram_init;
    logic [31:0] mem_ref [WORDS];
    logic [31:0] exp_rdata;

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0F0F;
    endfunction

    initial ram_init = 1'b0;
    always @(negedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < int'(WORDS); i++) ram[i] <= init_word(i);
            ram_init <= 1'b1;
        end else if (!bus.ram_nce && bus.ram_we) begin
            ram[bus.ram_addr] <= bus.ram_din;
        end
    end

    assign bus.ram_dout = ram[bus.ram_addr];

    // ---------------- reference model ----------------
    function automatic bit ref_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        if (sz == 2'd1) return a[0];
        if (sz >= 2'd2) return (a[1:0] != 2'b00);
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int lane_bits(input logic [1:0] sz);
        return (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
    endfunction

    function automatic int lane_off(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return int'(a[1:0]);
        if (sz == 2'd1) return a[1] ? 2 : 0;
        return 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic u, input logic [31:0] a);
        int nb;
        logic [31:0] mask;
        logic [31:0] v;
        nb = lane_bits(sz);
        if (nb == 32) return word;
        mask = (32'd1 << nb) - 32'd1;
        v = (word >> (8 * lane_off(sz, a))) & mask;
        if (!u && v[nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [31:0] a);
        int nb;
        int sh;
        logic [31:0] mask;
        nb = lane_bits(sz);
        if (nb == 32) return wd;
        mask = (32'd1 << nb) - 32'd1;
        sh = 8 * lane_off(sz, a);
        return (word & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issue one request from an IDLE cycle (#1 after a rising edge), follow it
    // to done, check it, and return one cycle after done.
    task automatic run_op(input string tag, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd_obs, output logic [31:0] din_obs);
        int          idx;
        bit          mis;
        logic [31:0] cur;
        logic [31:0] nw;
        int          lat_exp, nre_exp, nwe_exp;
        int          lat, nre, nwe, bad_acc;
        logic        err_obs;
        logic [31:0] rd_exp;

        idx     = int'((a >> 2) & 32'(WORDS - 1));
        cur     = mem_ref[idx];
        mis     = ref_mis(sz, a);
        nw      = ref_store(cur, wd, sz, a);
        lat_exp = mis ? 1 : (!w ? 2 : (sz >= 2'd2 ? 2 : 3));
        nre_exp = (!mis && (!w || sz < 2'd2)) ? 1 : 0;
        nwe_exp = (!mis && w) ? 1 : 0;
        rd_exp  = (!mis && !w) ? ref_load(cur, sz, u, a) : exp_rdata;

        check({tag, ":ready"}, 32'(bus.ready), 32'd1);
        bus.req = 1'b1; bus.wr = w; bus.size = sz; bus.uns = u;
        bus.byte_addr = a; bus.wdata = wd;
        @(posedge clk); #1;
        bus.req = 1'b0; bus.wr = $urandom_range(0, 1); bus.wdata = $urandom;

        lat = 0; nre = 0; nwe = 0; bad_acc = 0; err_obs = 1'bx;
        rd_obs = 'x; din_obs = 'x;
        for (int c = 1; c <= 8; c++) begin
            if (bus.ram_re || bus.ram_we) begin
                if (bus.ram_re) nre++;
                if (bus.ram_we) begin
                    nwe++;
                    din_obs = bus.ram_din;
                end
                if (bus.ram_nce !== 1'b0 || 32'(bus.ram_addr) !== 32'(idx)
                    || (bus.ram_re && bus.ram_we)) bad_acc++;
            end else if (bus.ram_nce !== 1'b1) begin
                bad_acc++;
            end
            if (bus.done === 1'b1) begin
                lat     = c;
                err_obs = bus.err;
                rd_obs  = bus.rdata;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;

        check({tag, ":latency"}, 32'(lat), 32'(lat_exp));
        check({tag, ":err"}, 32'(err_obs), 32'(mis));
        check({tag, ":rdata"}, rd_obs, rd_exp);
        check({tag, ":rd_cycles"}, 32'(nre), 32'(nre_exp));
        check({tag, ":wr_cycles"}, 32'(nwe), 32'(nwe_exp));
        check({tag, ":ram_ctl"}, 32'(bad_acc), 32'd0);
        if (nwe_exp == 1) check({tag, ":ram_din"}, din_obs, nw);
        check({tag, ":done_pulse"}, 32'(bus.done), 32'd0);

        if (!mis && w) mem_ref[idx] = nw;
        exp_rdata = rd_exp;
    endtask

    logic [31:0] rd, din;

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < int'(WORDS); i++) mem_ref[i] = init_word(i);
        exp_rdata = '0;
        nrst = 1'b0;
        bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'd0; bus.uns = 1'b0;
        bus.byte_addr = '0; bus.wdata = '0;

        // Reset state.
        #12;
        check("rst:ready", 32'(bus.ready), 32'd1);
        check("rst:done", 32'(bus.done), 32'd0);
        check("rst:err", 32'(bus.err), 32'd0);
        check("rst:rdata", bus.rdata, 32'd0);
        check("rst:ram_nce", 32'(bus.ram_nce), 32'd1);
        check("rst:ram_re", 32'(bus.ram_re), 32'd0);
        check("rst:ram_we", 32'(bus.ram_we), 32'd0);
        check("rst:ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rst:ram_din", bus.ram_din, 32'd0);
        @(negedge clk); nrst = 1'b1;
        @(posedge clk); #1;

        // Word store then load.
        run_op("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, din);
        check("sw10:din_const", din, 32'hDEADBEEF);
        run_op("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, din);
        check("lw10:const", rd, 32'hDEADBEEF);

        // Byte read-modify-write and byte loads.
        run_op("sw_setup", 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, rd, din);
        run_op("sb12", 1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA, rd, din);
        check("sb12:din_const", din, 32'h11AA3344);
        run_op("lb12", 1'b0, 2'd0, 1'b0, 32'h12, 32'h0, rd, din);
        check("lb12:const", rd, 32'hFFFFFFAA);
        run_op("lbu12", 1'b0, 2'd0, 1'b1, 32'h12, 32'h0, rd, din);
        check("lbu12:const", rd, 32'h000000AA);

        // Halfword loads of the upper lane.
        run_op("sw_half", 1'b1, 2'd2, 1'b0, 32'h10, 32'h80017FFF, rd, din);
        run_op("lh12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd, din);
        check("lh12:const", rd, 32'hFFFF8001);
        run_op("lhu12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd, din);
        check("lhu12:const", rd, 32'h00008001);

        // Misaligned word load.
        run_op("lw13", 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, rd, din);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        check("lw13:const", rd, 32'h00008001);
`else
        check("lw13:const", rd, 32'h80017FFF);
`endif

        // Address wrap: 0x810 aliases word 4.
        run_op("sw810", 1'b1, 2'd2, 1'b0, 32'h810, 32'h12345678, rd, din);
        run_op("lw10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, din);
        check("wrap:const", rd, 32'h12345678);

        // Reset during the WR cycle, before the falling edge.
        bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'd2; bus.uns = 1'b0;
        bus.byte_addr = 32'h10; bus.wdata = 32'h55AA55AA;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("rstwr:we_before", 32'(bus.ram_we), 32'd1);
        #1 nrst = 1'b0;
        #1;
        check("rstwr:we_low", 32'(bus.ram_we), 32'd0);
        check("rstwr:nce_high", 32'(bus.ram_nce), 32'd1);
        check("rstwr:no_done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        check("rstwr:no_done2", 32'(bus.done), 32'd0);
        nrst = 1'b1;
        @(posedge clk); #1;
        check("rstwr:ready", 32'(bus.ready), 32'd1);
        check("rstwr:word_kept", ram[4], mem_ref[4]);
        check("rstwr:rdata", bus.rdata, 32'd0);
        exp_rdata = '0;

        // Random traffic on a few words, with random high address bits.
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = $urandom & 32'hFFFF_F81F;
            run_op("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom, rd, din);
        end

        for (int i = 0; i < 8; i++) check("final_mem", ram[i], mem_ref[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
